// File: rtl/nested_loop_ctr_pkg.sv
// nested_loop_ctr_pkg: shared types for the nested loop counter
package nested_loop_ctr_pkg;
    typedef enum logic {CTR_WRAP, CTR_ONESHOT} ctr_mode_t;
    typedef enum logic [1:0] {CTR_IDLE, CTR_RUN, CTR_DONE} ctr_state_t;
endpackage

// File: rtl/nested_loop_ctr_level.sv
// loop_ctr_level: one level of the loop nest, counts 0..end and wraps
//   clk, rst      clock, synchronous active-high reset
//   clear         latch end_val, zero the counter
//   advance       step this level (carry reached it on a count edge)
//   end_val       inclusive terminal value, captured on clear
//   ctr_val       current index
//   at_end        combinational: ctr_val equals the latched terminal
//   wrapped       registered pulse, high the cycle after a wrap
module loop_ctr_level #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [WIDTH-1:0] end_val,
    output logic [WIDTH-1:0] ctr_val,
    output logic             at_end,
    output logic             wrapped
);
    logic [WIDTH-1:0] end_q;

    assign at_end = ctr_val == end_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_val <= '0;
            end_q   <= '0;
            wrapped <= 1'b0;
        end else if (clear) begin
            ctr_val <= '0;
            end_q   <= end_val;
            wrapped <= 1'b0;
        end else begin
            wrapped <= advance && at_end;
            if (advance)
                ctr_val <= at_end ? '0 : ctr_val + 1'b1;
        end
    end
endmodule

// File: rtl/nested_loop_ctr.sv
// nested_loop_ctr: cascaded loop counters (level 0 innermost) with wrap/one-shot modes
//   clk, rst      clock, synchronous active-high reset
//   enable        advance permission while running
//   load          latch end_val/mode, clear counters, start a run
//   mode          CTR_WRAP or CTR_ONESHOT, sampled on load
//   end_val       inclusive terminal value per level
//   ctr_val       current index per level
//   level_event   per-level one-cycle wrap/final pulse
//   busy, done    running / one-shot completed
module nested_loop_ctr
    import nested_loop_ctr_pkg::*;
#(
    parameter int NUM_LEVELS    = 3,
    parameter int COUNTER_WIDTH = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     enable,
    input  logic                                     load,
    input  ctr_mode_t                                mode,
    input  logic [NUM_LEVELS-1:0][COUNTER_WIDTH-1:0] end_val,
    output logic [NUM_LEVELS-1:0][COUNTER_WIDTH-1:0] ctr_val,
    output logic [NUM_LEVELS-1:0]                    level_event,
    output logic                                     busy,
    output logic                                     done
);
    ctr_state_t            state_q, state_d;
    ctr_mode_t             mode_q;
    logic [NUM_LEVELS:0]   carry;
    logic [NUM_LEVELS-1:0] at_end, wrapped;
    logic                  count, final_edge, final_q;

    // carry[NUM_LEVELS] high means every level sits at its terminal value
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_LEVELS; i++) begin : g_level
            assign carry[i+1] = carry[i] && at_end[i];
            // the final one-shot edge must not advance: counters hold at end
            loop_ctr_level #(.WIDTH(COUNTER_WIDTH)) u_level (
                .clk     (clk),
                .rst     (rst),
                .clear   (load),
                .advance (count && carry[i] && !final_edge),
                .end_val (end_val[i]),
                .ctr_val (ctr_val[i]),
                .at_end  (at_end[i]),
                .wrapped (wrapped[i])
            );
        end
    endgenerate

    always_comb begin
        count      = state_q == CTR_RUN && enable && !load;
        final_edge = count && mode_q == CTR_ONESHOT && carry[NUM_LEVELS];
        state_d    = load ? CTR_RUN : final_edge ? CTR_DONE : state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTR_IDLE;
            mode_q  <= CTR_WRAP;
            final_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= load ? mode : mode_q;
            final_q <= final_edge;
        end
    end

    // held counters do not wrap on the final edge, so its pulse comes from final_q
    assign level_event = wrapped | {NUM_LEVELS{final_q}};
    assign busy        = state_q == CTR_RUN;
    assign done        = state_q == CTR_DONE;
endmodule

// File: tb/tb_nested_loop_ctr.sv
// tb_nested_loop_ctr: scoreboard bench for nested_loop_ctr against a mixed-radix position model
module tb_nested_loop_ctr;
    import nested_loop_ctr_pkg::*;

    localparam int N = 3;
    localparam int W = 6;

    typedef struct packed {
        logic [N-1:0][W-1:0] ctr;
        logic [N-1:0]        ev;
        logic                busy;
        logic                done;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst, enable, load;
    ctr_mode_t           mode;
    logic [N-1:0][W-1:0] end_val, ctr_val;
    logic [N-1:0]        level_event;
    logic                busy, done;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int   m_end[N];
    bit   m_run, m_done, m_os;
    int   p;

    nested_loop_ctr #(.NUM_LEVELS(N), .COUNTER_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .mode        (mode),
        .end_val     (end_val),
        .ctr_val     (ctr_val),
        .level_event (level_event),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // product of the radices of levels below k: the loop nest is a mixed-radix number
    function automatic int radix_prod(int k);
        int r = 1;
        for (int j = 0; j < k; j++) r *= m_end[j] + 1;
        return r;
    endfunction

    function automatic exp_t expected(logic [N-1:0] ev);
        exp_t e;
        for (int i = 0; i < N; i++)
            e.ctr[i] = W'((p / radix_prod(i)) % (m_end[i] + 1));
        e.ev   = ev;
        e.busy = m_run;
        e.done = m_done;
        return e;
    endfunction

    task automatic cyc(input bit r, input bit l, input bit e, input ctr_mode_t md,
                       input logic [N-1:0][W-1:0] ev_in);
        logic [N-1:0] ev;
        int total;
        rst = r; load = l; enable = e; mode = md; end_val = ev_in;
        @(posedge clk);
        #1;
        ev = '0;
        if (r) begin
            m_run = 0; m_done = 0; m_os = 0; p = 0;
            for (int i = 0; i < N; i++) m_end[i] = 0;
        end else if (l) begin
            for (int i = 0; i < N; i++) m_end[i] = int'(ev_in[i]);
            m_os = md == CTR_ONESHOT; m_run = 1; m_done = 0; p = 0;
        end else if (m_run && e) begin
            total = radix_prod(N);
            if (m_os && p == total - 1) begin
                ev = '1; m_run = 0; m_done = 1;
            end else begin
                p = (p + 1) % total;
                for (int i = 0; i < N; i++) ev[i] = (p % radix_prod(i + 1)) == 0;
            end
        end
        sb.push_back(expected(ev));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check("ctr_val", 32'(ctr_val), 32'(x.ctr));
            check("level_event", 32'(level_event), 32'(x.ev));
            check("busy", 32'(busy), 32'(x.busy));
            check("done", 32'(done), 32'(x.done));
        end
    end

    task automatic run(input bit e, input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, e, CTR_WRAP, end_val);
    endtask

    task automatic ld(input ctr_mode_t md, input logic [N-1:0][W-1:0] ev);
        cyc(0, 1, 0, md, ev);
    endtask

    initial begin
        logic [N-1:0][W-1:0] rv;
        end_val = '0;
        cyc(1, 0, 0, CTR_WRAP, '0);
        cyc(1, 0, 1, CTR_WRAP, '0);
        run(1, 3);
        ld(CTR_WRAP, {6'd2, 6'd1, 6'd3});
        run(0, 5);
        ld(CTR_WRAP, {6'd0, 6'd0, 6'd15});
        run(1, 20);
        ld(CTR_WRAP, {6'd1, 6'd2, 6'd3});
        run(1, 30);
        ld(CTR_ONESHOT, {6'd1, 6'd2, 6'd3});
        run(1, 35);
        ld(CTR_WRAP, {6'd1, 6'd2, 6'd3});
        run(1, 2);
        run(0, 5);
        run(1, 3);
        ld(CTR_WRAP, {6'd0, 6'd0, 6'd4});
        run(1, 12);
        cyc(0, 1, 1, CTR_WRAP, {6'd0, 6'd0, 6'd4});
        run(1, 3);
        cyc(1, 0, 1, CTR_WRAP, '0);
        run(1, 5);
        ld(CTR_WRAP, {6'd0, 6'd0, 6'd63});
        run(1, 70);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++)
                rv[i] = ($urandom_range(0, 9) == 0) ? W'(63) : W'($urandom_range(0, 3));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 3) != 0, ctr_mode_t'($urandom_range(0, 1)), rv);
        end
        repeat (2) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
